// File: rtl/rename_unit_multi_pkg.sv
// Shared types for the rename stage.
//   arch_addr_t  : 5-bit architectural register address
//   phy_addr_t   : physical register address for the default 64-entry file
//   commit_rec_t : one ROB commit record {rd_arch, rd_phy, rd_origin}
//   PHY_ZERO     : the hardwired-zero physical register
package rename_unit_multi_pkg;

  localparam int ARCH_W       = 5;
  localparam int PKG_PHY_REGS = 64;
  localparam int PKG_PW       = $clog2(PKG_PHY_REGS);

  typedef logic [ARCH_W-1:0] arch_addr_t;
  typedef logic [PKG_PW-1:0] phy_addr_t;

  typedef struct packed {
    arch_addr_t rd_arch;
    phy_addr_t  rd_phy;
    phy_addr_t  rd_origin;
  } commit_rec_t;

  localparam phy_addr_t PHY_ZERO = '0;

endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers.
// Pops up to DECODE_WIDTH entries from the speculative head per cycle, pushes
// up to COMMIT_WIDTH recycled registers at the tail in commit order, and keeps
// a committed head that the speculative head reloads from on flush.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pop_cnt             entries consumed this cycle (0 when nothing fires)
//   push_valid/push_phy recycled registers, compacted at the tail in slot order
//   cm_adv              committed-head advance this cycle
//   flush               reload speculative head from the next committed head
//   alloc_phy           the DECODE_WIDTH entries starting at the head
//   free_count          tail - head
module rename_free_list
  import rename_unit_multi_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int PHY_REGS     = 64,
  parameter int PW           = $clog2(PHY_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [2:0]                           pop_cnt,
  input  logic [COMMIT_WIDTH-1:0]              push_valid,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]      push_phy,
  input  logic [2:0]                           cm_adv,
  input  logic                                 flush,
  output logic [DECODE_WIDTH-1:0][PW-1:0]      alloc_phy,
  output logic [PW:0]                          free_count
);

  logic [PW-1:0] mem [PHY_REGS];
  logic [PW:0]   head, tail, cm_head, cm_head_n;
  logic [COMMIT_WIDTH-1:0][PW-1:0] push_addr;
  logic [2:0]    push_cnt;

  // Pushes are packed back to back at the tail, skipping invalid slots.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      push_addr[i] = tail[PW-1:0] + PW'(push_cnt);
      if (push_valid[i]) push_cnt = push_cnt + 3'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < DECODE_WIDTH; k++)
      alloc_phy[k] = mem[head[PW-1:0] + PW'(k)];
  end

  assign cm_head_n  = cm_head + (PW+1)'(cm_adv);
  assign free_count = tail - head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHY_REGS-1; i++) mem[i] <= PW'(i + 1);
      mem[PHY_REGS-1] <= PW'(PHY_ZERO);
      head    <= '0;
      cm_head <= '0;
      tail    <= (PW+1)'(PHY_REGS - 1);
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (push_valid[i]) mem[push_addr[i]] <= push_phy[i];
      tail    <= tail + (PW+1)'(push_cnt);
      cm_head <= cm_head_n;
      head    <= flush ? cm_head_n : head + (PW+1)'(pop_cnt);
    end
  end

endmodule

// File: rtl/rename_unit_multi.sv
// Superscalar register rename stage with speculative and committed RATs.
// Optional feature macro: RENAME_PERF_CNT_EN (adds perf_stall_cycles and
// perf_renamed 32-bit wrapping counters).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   dec_valid, dec_slot_valid     decode group valid / per-slot valid
//   dec_rd/rs1/rs2_en, *_arch     operand enables and arch addresses
//   rename_ready                  group can be accepted this cycle
//   ren_rd/rs1/rs2_phy, ren_rd_origin  combinational rename results
//   rt_wen, rt_addr               ready-table busy-set strobes
//   cm_valid, cm_rd_arch, cm_rd_phy, cm_rd_origin  ROB commits
//   flush                         restore speculative state from committed
module rename_unit_multi
  import rename_unit_multi_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int PHY_REGS     = 64,
  parameter int PW           = $clog2(PHY_REGS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dec_valid,
  input  logic [DECODE_WIDTH-1:0]           dec_slot_valid,
  input  logic [DECODE_WIDTH-1:0]           dec_rd_en,
  input  logic [DECODE_WIDTH-1:0]           dec_rs1_en,
  input  logic [DECODE_WIDTH-1:0]           dec_rs2_en,
  input  arch_addr_t [DECODE_WIDTH-1:0]     dec_rd_arch,
  input  arch_addr_t [DECODE_WIDTH-1:0]     dec_rs1_arch,
  input  arch_addr_t [DECODE_WIDTH-1:0]     dec_rs2_arch,
  output logic                              rename_ready,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   ren_rd_phy,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   ren_rs1_phy,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   ren_rs2_phy,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   ren_rd_origin,
  output logic [DECODE_WIDTH-1:0]           rt_wen,
  output logic [DECODE_WIDTH-1:0][PW-1:0]   rt_addr,
  input  logic [COMMIT_WIDTH-1:0]           cm_valid,
  input  arch_addr_t [COMMIT_WIDTH-1:0]     cm_rd_arch,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]   cm_rd_phy,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]   cm_rd_origin,
  input  logic                              flush
`ifdef RENAME_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_stall_cycles,
  output logic [31:0]                       perf_renamed
`endif
);

  logic [DECODE_WIDTH-1:0]          alloc;
  logic [DECODE_WIDTH-1:0][2:0]     alloc_idx;
  logic [2:0]                       need;
  logic [DECODE_WIDTH-1:0][PW-1:0]  alloc_phy, new_phy;
  logic [PW:0]                      free_count;
  logic                             fire;
  logic [COMMIT_WIDTH-1:0]          push_valid;
  logic [2:0]                       cm_adv;
  logic [PW-1:0] rat [32];
  logic [PW-1:0] rat_n [32];
  logic [PW-1:0] crat [32];
  logic [PW-1:0] crat_n [32];

  // Allocating slots take free-list entries in slot order; alloc_idx is the
  // number of allocating slots older than each slot.
  always_comb begin
    need = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      alloc[j]     = dec_slot_valid[j] & dec_rd_en[j] & (dec_rd_arch[j] != '0);
      alloc_idx[j] = need;
      if (alloc[j]) need = need + 3'd1;
    end
  end

  always_comb begin
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      new_phy[j] = PW'(PHY_ZERO);
      for (int k = 0; k < DECODE_WIDTH; k++)
        if (alloc[j] && alloc_idx[j] == 3'(k)) new_phy[j] = alloc_phy[k];
    end
  end

  assign rename_ready = (free_count >= (PW+1)'(need)) & ~flush;
  assign fire         = dec_valid & rename_ready;

  // Youngest older in-group writer of the same arch register overrides the RAT.
  function automatic logic [PW-1:0] src_lookup(input arch_addr_t a, input int j,
                                                input logic [PW-1:0] rat_val);
    logic [PW-1:0] r;
    r = rat_val;
    for (int k = 0; k < DECODE_WIDTH; k++)
      if (k < j && alloc[k] && dec_rd_arch[k] == a) r = new_phy[k];
    if (a == '0) r = PW'(PHY_ZERO);
    return r;
  endfunction

  always_comb begin
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      ren_rd_phy[j]    = new_phy[j];
      ren_rs1_phy[j]   = dec_rs1_en[j] ? src_lookup(dec_rs1_arch[j], j, rat[dec_rs1_arch[j]])
                                       : PW'(PHY_ZERO);
      ren_rs2_phy[j]   = dec_rs2_en[j] ? src_lookup(dec_rs2_arch[j], j, rat[dec_rs2_arch[j]])
                                       : PW'(PHY_ZERO);
      ren_rd_origin[j] = alloc[j] ? src_lookup(dec_rd_arch[j], j, rat[dec_rd_arch[j]])
                                  : PW'(PHY_ZERO);
      rt_wen[j]        = fire & alloc[j];
      rt_addr[j]       = new_phy[j];
    end
  end

  always_comb begin
    cm_adv = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      push_valid[i] = cm_valid[i] & (cm_rd_origin[i] != PW'(PHY_ZERO));
      if (cm_valid[i] && cm_rd_phy[i] != PW'(PHY_ZERO)) cm_adv = cm_adv + 3'd1;
    end
  end

  // Arch 0 is never written so the zero mapping holds in both tables.
  always_comb begin
    crat_n = crat;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (cm_valid[i] && cm_rd_arch[i] != '0) crat_n[cm_rd_arch[i]] = cm_rd_phy[i];
  end

  always_comb begin
    rat_n = rat;
    if (flush) begin
      rat_n = crat_n;
    end else if (fire) begin
      for (int j = 0; j < DECODE_WIDTH; j++)
        if (alloc[j]) rat_n[dec_rd_arch[j]] = new_phy[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) begin
        rat[a]  <= '0;
        crat[a] <= '0;
      end
    end else begin
      rat  <= rat_n;
      crat <= crat_n;
    end
  end

  rename_free_list #(
    .DECODE_WIDTH(DECODE_WIDTH),
    .COMMIT_WIDTH(COMMIT_WIDTH),
    .PHY_REGS    (PHY_REGS),
    .PW          (PW)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop_cnt   (fire ? need : 3'd0),
    .push_valid(push_valid),
    .push_phy  (cm_rd_origin),
    .cm_adv    (cm_adv),
    .flush     (flush),
    .alloc_phy (alloc_phy),
    .free_count(free_count)
  );

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] slot_cnt;

  always_comb begin
    slot_cnt = '0;
    for (int j = 0; j < DECODE_WIDTH; j++)
      if (dec_slot_valid[j]) slot_cnt = slot_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_renamed      <= '0;
    end else begin
      if (dec_valid && !rename_ready && !flush) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (fire) perf_renamed <= perf_renamed + slot_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_rename_unit_multi.sv
module tb_rename_unit_multi;
  localparam int DW = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  logic dec_valid;
  logic [DW-1:0] dec_slot_valid, dec_rd_en, dec_rs1_en, dec_rs2_en;
  logic [DW-1:0][4:0] dec_rd_arch, dec_rs1_arch, dec_rs2_arch;
  logic rename_ready;
  logic [DW-1:0][5:0] ren_rd_phy, ren_rs1_phy, ren_rs2_phy, ren_rd_origin, rt_addr;
  logic [DW-1:0] rt_wen;
  logic [CW-1:0] cm_valid;
  logic [CW-1:0][4:0] cm_rd_arch;
  logic [CW-1:0][5:0] cm_rd_phy, cm_rd_origin;
  logic flush;
`ifdef RENAME_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_renamed;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rename_unit_multi #(.DECODE_WIDTH(DW), .COMMIT_WIDTH(CW), .PHY_REGS(64)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_slot_valid(dec_slot_valid),
    .dec_rd_en(dec_rd_en), .dec_rs1_en(dec_rs1_en), .dec_rs2_en(dec_rs2_en),
    .dec_rd_arch(dec_rd_arch), .dec_rs1_arch(dec_rs1_arch), .dec_rs2_arch(dec_rs2_arch),
    .rename_ready(rename_ready), .ren_rd_phy(ren_rd_phy), .ren_rs1_phy(ren_rs1_phy),
    .ren_rs2_phy(ren_rs2_phy), .ren_rd_origin(ren_rd_origin), .rt_wen(rt_wen),
    .rt_addr(rt_addr), .cm_valid(cm_valid), .cm_rd_arch(cm_rd_arch),
    .cm_rd_phy(cm_rd_phy), .cm_rd_origin(cm_rd_origin), .flush(flush)
`ifdef RENAME_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_renamed(perf_renamed)
`endif
  );

  task automatic clear_inputs();
    dec_valid = 0; dec_slot_valid = '0; dec_rd_en = '0; dec_rs1_en = '0; dec_rs2_en = '0;
    dec_rd_arch = '0; dec_rs1_arch = '0; dec_rs2_arch = '0;
    cm_valid = '0; cm_rd_arch = '0; cm_rd_phy = '0; cm_rd_origin = '0; flush = 0;
  endtask

  task automatic set_slot(input int j, input logic rd_en, input logic [4:0] rd,
                          input logic rs1_en, input logic [4:0] rs1,
                          input logic rs2_en, input logic [4:0] rs2);
    dec_slot_valid[j] = 1'b1;
    dec_rd_en[j] = rd_en;   dec_rd_arch[j] = rd;
    dec_rs1_en[j] = rs1_en; dec_rs1_arch[j] = rs1;
    dec_rs2_en[j] = rs2_en; dec_rs2_arch[j] = rs2;
  endtask

  task automatic set_cm(input int i, input logic [4:0] arch, input logic [5:0] phy,
                        input logic [5:0] origin);
    cm_valid[i] = 1'b1; cm_rd_arch[i] = arch; cm_rd_phy[i] = phy; cm_rd_origin[i] = origin;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  // Renames {rd x1, rd x2} from a fresh reset, which allocates phys 1 and 2.
  task automatic rename_x1_x2();
    clear_inputs();
    set_slot(0, 1, 5'd1, 0, 0, 0, 0);
    set_slot(1, 1, 5'd2, 0, 0, 0, 0);
    dec_valid = 1;
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (rename_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", rename_ready); end
    checks++; if (rt_wen !== 2'b00) begin errors++; $display("FAIL reset_rt_wen: got %b exp 00", rt_wen); end
    set_slot(0, 0, 0, 1, 5'd7, 1, 5'd9);
    #1;
    checks++; if (ren_rs1_phy[0] !== 6'd0 || ren_rs2_phy[0] !== 6'd0) begin
      errors++; $display("FAIL reset_rat: got rs1=%0d rs2=%0d exp 0 0", ren_rs1_phy[0], ren_rs2_phy[0]); end
    cyc();
  endtask

  task automatic test_basic();
    do_reset();
    set_slot(0, 1, 5'd1, 0, 0, 0, 0);
    set_slot(1, 1, 5'd2, 0, 0, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (ren_rd_phy[0] !== 6'd1 || ren_rd_phy[1] !== 6'd2) begin
      errors++; $display("FAIL basic_rd_phy: got %0d,%0d exp 1,2", ren_rd_phy[0], ren_rd_phy[1]); end
    checks++; if (rt_wen !== 2'b11 || rt_addr[1] !== 6'd2) begin
      errors++; $display("FAIL basic_rt: got wen=%b addr1=%0d exp 11,2", rt_wen, rt_addr[1]); end
    cyc();
    clear_inputs();
    set_slot(0, 0, 0, 1, 5'd1, 0, 0);
    set_slot(1, 1, 5'd3, 0, 0, 1, 5'd2);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (ren_rs1_phy[0] !== 6'd1 || ren_rs2_phy[1] !== 6'd2) begin
      errors++; $display("FAIL basic_src: got rs1=%0d rs2=%0d exp 1,2", ren_rs1_phy[0], ren_rs2_phy[1]); end
    checks++; if (ren_rd_phy[0] !== 6'd0 || ren_rd_phy[1] !== 6'd3 || rt_wen !== 2'b10) begin
      errors++; $display("FAIL basic_partial: got rd=%0d,%0d wen=%b exp 0,3,10", ren_rd_phy[0], ren_rd_phy[1], rt_wen); end
    dec_valid = 0;
    #1;
    checks++; if (rt_wen !== 2'b00) begin errors++; $display("FAIL basic_nofire_wen: got %b exp 00", rt_wen); end
    cyc();
  endtask

  // Continues from test_basic: head at phy 3.
  task automatic test_bypass();
    clear_inputs();
    set_slot(0, 1, 5'd5, 0, 0, 0, 0);
    set_slot(1, 1, 5'd5, 1, 5'd5, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (ren_rs1_phy[1] !== 6'd3 || ren_rd_phy[1] !== 6'd4) begin
      errors++; $display("FAIL bypass_src: got rs1=%0d rd=%0d exp 3,4", ren_rs1_phy[1], ren_rd_phy[1]); end
    checks++; if (ren_rd_origin[1] !== 6'd3 || ren_rd_origin[0] !== 6'd0) begin
      errors++; $display("FAIL bypass_origin: got %0d,%0d exp 0,3", ren_rd_origin[0], ren_rd_origin[1]); end
    cyc();
    clear_inputs();
    set_slot(0, 0, 0, 1, 5'd5, 0, 0);
    @(negedge clk);
    checks++; if (ren_rs1_phy[0] !== 6'd4) begin errors++; $display("FAIL bypass_rat: got %0d exp 4", ren_rs1_phy[0]); end
    cyc();
  endtask

  // Continues from test_bypass: phys 1..4 allocated, 59 remain.
  task automatic test_exhaust();
    for (int i = 0; i < 59; i++) begin
      clear_inputs();
      set_slot(0, 1, 5'd6, 0, 0, 0, 0);
      dec_valid = 1;
      @(negedge clk);
      checks++; if (rename_ready !== 1'b1 || ren_rd_phy[0] !== 6'(5 + i)) begin
        errors++; $display("FAIL exhaust_alloc %0d: got ready=%0b phy=%0d exp 1,%0d", i, rename_ready, ren_rd_phy[0], 5 + i); end
      cyc();
    end
    clear_inputs();
    set_slot(0, 1, 5'd6, 0, 0, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (rename_ready !== 1'b0 || rt_wen !== 2'b00) begin
      errors++; $display("FAIL exhaust_empty: got ready=%0b wen=%b exp 0,00", rename_ready, rt_wen); end
    dec_rd_arch[0] = 5'd0;
    #1;
    checks++; if (rename_ready !== 1'b1 || rt_wen !== 2'b00) begin
      errors++; $display("FAIL exhaust_x0: got ready=%0b wen=%b exp 1,00", rename_ready, rt_wen); end
    cyc();
    clear_inputs();
    set_slot(0, 1, 5'd6, 0, 0, 0, 0);
    dec_valid = 1;
    set_cm(0, 5'd1, 6'd1, 6'd3);
    set_cm(1, 5'd2, 6'd2, 6'd5);
    @(negedge clk);
    checks++; if (rename_ready !== 1'b0) begin errors++; $display("FAIL exhaust_commit_latency: got ready=%0b exp 0", rename_ready); end
    cyc();
    clear_inputs();
    set_slot(0, 1, 5'd7, 0, 0, 0, 0);
    set_slot(1, 1, 5'd8, 0, 0, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (rename_ready !== 1'b1 || ren_rd_phy[0] !== 6'd3 || ren_rd_phy[1] !== 6'd5) begin
      errors++; $display("FAIL exhaust_recycle: got ready=%0b rd=%0d,%0d exp 1,3,5", rename_ready, ren_rd_phy[0], ren_rd_phy[1]); end
    cyc();
    clear_inputs();
    @(negedge clk);
    checks++; if (rename_ready !== 1'b1) begin errors++; $display("FAIL exhaust_empty_group: got ready=%0b exp 1", rename_ready); end
    cyc();
  endtask

  task automatic test_flush();
    do_reset();
    rename_x1_x2();
    set_cm(0, 5'd1, 6'd1, 6'd0);
    cyc();
    clear_inputs();
    flush = 1;
    set_slot(0, 1, 5'd7, 0, 0, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (rename_ready !== 1'b0 || rt_wen !== 2'b00) begin
      errors++; $display("FAIL flush_block: got ready=%0b wen=%b exp 0,00", rename_ready, rt_wen); end
    cyc();
    clear_inputs();
    set_slot(0, 1, 5'd3, 1, 5'd1, 1, 5'd2);
    @(negedge clk);
    checks++; if (ren_rs1_phy[0] !== 6'd1 || ren_rs2_phy[0] !== 6'd0) begin
      errors++; $display("FAIL flush_rat: got x1=%0d x2=%0d exp 1,0", ren_rs1_phy[0], ren_rs2_phy[0]); end
    checks++; if (ren_rd_phy[0] !== 6'd2) begin errors++; $display("FAIL flush_head: got %0d exp 2", ren_rd_phy[0]); end
    cyc();
  endtask

  task automatic test_flush_commit();
    do_reset();
    rename_x1_x2();
    set_cm(0, 5'd1, 6'd1, 6'd0);
    cyc();
    clear_inputs();
    flush = 1;
    set_cm(0, 5'd2, 6'd2, 6'd0);
    set_slot(0, 1, 5'd9, 0, 0, 0, 0);
    dec_valid = 1;
    @(negedge clk);
    checks++; if (rename_ready !== 1'b0 || rt_wen !== 2'b00) begin
      errors++; $display("FAIL flushcm_block: got ready=%0b wen=%b exp 0,00", rename_ready, rt_wen); end
    cyc();
    clear_inputs();
    set_slot(0, 1, 5'd4, 1, 5'd2, 1, 5'd1);
    @(negedge clk);
    checks++; if (ren_rs1_phy[0] !== 6'd2 || ren_rs2_phy[0] !== 6'd1) begin
      errors++; $display("FAIL flushcm_rat: got x2=%0d x1=%0d exp 2,1", ren_rs1_phy[0], ren_rs2_phy[0]); end
    checks++; if (ren_rd_phy[0] !== 6'd3) begin errors++; $display("FAIL flushcm_head: got %0d exp 3", ren_rd_phy[0]); end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    rename_x1_x2();
    set_slot(0, 0, 0, 1, 5'd1, 0, 0);
    @(negedge clk);
    checks++; if (ren_rs1_phy[0] !== 6'd1) begin errors++; $display("FAIL areset_pre: got %0d exp 1", ren_rs1_phy[0]); end
    #2 rst = 1;
    #1;
    checks++; if (ren_rs1_phy[0] !== 6'd0) begin errors++; $display("FAIL areset_rat: got %0d exp 0", ren_rs1_phy[0]); end
    cyc();
    rst = 0;
    clear_inputs();
    set_slot(0, 1, 5'd1, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (ren_rd_phy[0] !== 6'd1) begin errors++; $display("FAIL areset_freelist: got %0d exp 1", ren_rd_phy[0]); end
    cyc();
  endtask

`ifdef RENAME_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 63; i++) begin
      clear_inputs();
      set_slot(0, 1, 5'd6, 0, 0, 0, 0);
      dec_valid = 1;
      cyc();
    end
    @(negedge clk);
    checks++; if (perf_renamed !== 32'd63 || perf_stall_cycles !== 32'd0) begin
      errors++; $display("FAIL perf_fill: got renamed=%0d stall=%0d exp 63,0", perf_renamed, perf_stall_cycles); end
    clear_inputs();
    set_slot(0, 1, 5'd1, 0, 0, 0, 0);
    set_slot(1, 1, 5'd2, 0, 0, 0, 0);
    dec_valid = 1;
    cyc(); cyc();
    set_cm(0, 5'd1, 6'd1, 6'd3);
    set_cm(1, 5'd2, 6'd2, 6'd5);
    cyc();
    cm_valid = '0;
    cyc();
    clear_inputs();
    @(negedge clk);
    checks++; if (perf_stall_cycles !== 32'd3 || perf_renamed !== 32'd65) begin
      errors++; $display("FAIL perf_counts: got stall=%0d renamed=%0d exp 3,65", perf_stall_cycles, perf_renamed); end
    cyc();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_basic();
    test_bypass();
    test_exhaust();
    test_flush();
    test_flush_commit();
    test_async_reset();
`ifdef RENAME_PERF_CNT_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_unit_multi.md
# rename_unit_multi

Superscalar register-rename stage: renames up to DECODE_WIDTH decoded instructions per cycle against a speculative RAT, allocates physical destinations from a circular free list, and recycles superseded physical registers from up to COMMIT_WIDTH ROB commits per cycle. It sits between the decoder and dispatch/ROB. It keeps a committed RAT and a committed free-list head, so a pipeline flush restores precise state in one cycle.

## Interface
Parameters:
- DECODE_WIDTH, 2: instructions renamed per cycle (1..4).
- COMMIT_WIDTH, 2: ROB commits accepted per cycle (1..4).
- PHY_REGS, 64: physical registers, power of two. Phy 0 is the hardwired zero.
- PW, $clog2(PHY_REGS): physical address width (derived).

Ports (arrays indexed by slot; slot 0 is oldest):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode group valid
- dec_slot_valid  in  DECODE_WIDTH  per-slot valid; contiguous from slot 0
- dec_rd_en / dec_rs1_en / dec_rs2_en  in  DECODE_WIDTH each  operand enables
- dec_rd_arch / dec_rs1_arch / dec_rs2_arch  in  DECODE_WIDTH×5  architectural addresses
- rename_ready  out  1  group can be accepted this cycle
- ren_rd_phy / ren_rs1_phy / ren_rs2_phy / ren_rd_origin  out  DECODE_WIDTH×PW  rename results
- rt_wen  out  DECODE_WIDTH  ready-table clear (busy set) strobes
- rt_addr  out  DECODE_WIDTH×PW  ready-table addresses
- cm_valid  in  COMMIT_WIDTH  per-commit valid, contiguous from slot 0, in program order
- cm_rd_arch  in  COMMIT_WIDTH×5
- cm_rd_phy / cm_rd_origin  in  COMMIT_WIDTH×PW
- flush  in  1  restore speculative state from committed state

## Operation
- Slot j needs an allocation when it is valid, its rd_en is set and rd_arch≠0. need = popcount of slots that need an allocation.
- rename_ready = (free_count ≥ need) & ~flush. fire = dec_valid & rename_ready. A group is accepted whole or not at all.
- Allocation order: allocating slots take free-list entries head, head+1, … in slot order. A non-allocating slot outputs ren_rd_phy=0.
- Source lookup for slot j: take the youngest older slot k<j in the group that allocates the same arch register and use its new phy. Otherwise read the RAT. A disabled operand outputs 0. Arch 0 always yields phy 0.
- ren_rd_origin uses the same bypass rule applied to rd_arch.
- On fire:
  - RAT[rd_arch] gets the allocated phy; the youngest writer in the group wins.
  - head advances by need.
  - rt_wen=1 for allocating slots, with rt_addr = new phy.
  - When fire=0, rt_wen=0.
- For each valid commit i:
  - Committed RAT[cm_rd_arch] gets cm_rd_phy; the youngest commit wins.
  - If cm_rd_origin≠0, push it at the free-list tail in commit order.
  - If cm_rd_phy≠0, the committed head advances by 1.
- On flush:
  - RAT and head load the next-state committed RAT and committed head, including same-cycle commits.
  - Pushes in the flush cycle still occur.
  - No group fires.
- free_count = tail − head, using PW+1-bit pointers with a wrap bit. The list never overflows, because at most PHY_REGS−1 entries are live.

## Timing
- Rename outputs are combinational from decode inputs and the current RAT. RAT/head updates become visible the next cycle. Commit-to-allocatable latency is 1 cycle.
- Reset values:
  - RAT and committed RAT all 0.
  - Free list holds phys 1..PHY_REGS−1 in ascending order.
  - head = committed head = 0; tail = PHY_REGS−1; free_count = PHY_REGS−1.
  - rename_ready=1, rt_wen=0.
- Reset asserted mid-operation discards all state immediately, independent of clk.
- Pointer wrap-around is modulo PHY_REGS; the wrap bit distinguishes full from empty.

## Configuration
- RENAME_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_stall_cycles (increments when dec_valid & ~rename_ready & ~flush) and perf_renamed (increments by the popcount of valid slots on fire).
  - Both wrap, and both reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- The shared package holds:
  - arch_addr_t (5b) and phy_addr_t (PW b).
  - The commit record struct {rd_arch, rd_phy, rd_origin}.
  - A constant PHY_ZERO=0.
- One sub-module, rename_free_list, contains:
  - The circular buffer with multi-pop/multi-push.
  - The speculative and committed head pointers, and the flush restore.
- RAT, bypass logic and committed RAT stay in the top module.

## Test plan
- After reset, group {rd x1, rd x2} → ren_rd_phy 1,2; rt_wen=2'b11. Next cycle, rs1=x1 → phy 1.
- Same group: slot0 rd x5, slot1 rs1=x5, rd x5 → slot1 rs1_phy = slot0 new phy, rd_origin = slot0 phy. RAT[x5] ends at slot1's phy.
- Allocate 63 regs one per cycle → free_count 0 and rename_ready drops for a group needing ≥1. A group with rd x0 only still fires. Commit with rd_origin=3 → ready again next cycle, and phy 3 is handed out.
- Rename x1→1, x2→2; commit x1 only; flush → RAT x1=1, x2=0; next allocation gets phy 2 (head rewound).
- Flush in the same cycle as commit of x2 (rd_phy 2) → restored RAT x2=2, and no group fires that cycle.
- With RENAME_PERF_CNT_EN: 3 stall cycles then one 2-slot fire → perf_stall_cycles=3, perf_renamed=2.
